// File: rtl/sd_reg_arbiter.sv
// Two-requester round-robin arbiter for the SD register bus.
// Supports a lockable owner reservation with an idle timeout.
module sd_reg_arbiter #(
    parameter int LOCK_TIMEOUT = 256
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic       req1,
    input  logic       we0,
    input  logic       we1,
    input  logic [6:0] addr0,
    input  logic [6:0] addr1,
    input  logic [7:0] wdata0,
    input  logic [7:0] wdata1,
    input  logic       lock0,
    input  logic       lock1,
    output logic       ack0,
    output logic       ack1,
    output logic [7:0] rdata0,
    output logic [7:0] rdata1,
    output logic [6:0] sd_addr,
    output logic       sd_we,
    output logic [7:0] sd_data_o,
    input  logic [7:0] sd_data_i,
    output logic       owner,
    output logic       busy
);

    localparam int TW = ($clog2(LOCK_TIMEOUT + 1) > 8) ?
                        $clog2(LOCK_TIMEOUT + 1) : 8;
    localparam logic [TW-1:0] TMAX = TW'(LOCK_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        COMPLETE
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic          cur;
    logic          we_q;
    logic          lock_q;
    logic          last;
    logic          locked;
    logic [TW-1:0] tcnt;
    logic          el0;
    logic          el1;
    logic          grant;
    logic          win;
    logic          own_req;
    logic          expire;

    // A reservation makes the non-owner ineligible.
    always_comb begin
        el0      = req0 & ~(locked & owner);
        el1      = req1 & ~(locked & ~owner);
        grant    = el0 | el1;
        win      = (el0 & el1) ? ~last : el1;
        own_req  = owner ? req1 : req0;
        expire   = locked & ~own_req & (tcnt == TMAX);
        state_nx = state;
        unique case (state)
            IDLE:     if (grant) state_nx = ACCESS;
            ACCESS:   state_nx = COMPLETE;
            COMPLETE: state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cur       <= 1'b0;
            we_q      <= 1'b0;
            lock_q    <= 1'b0;
            last      <= 1'b1;
            locked    <= 1'b0;
            tcnt      <= '0;
            owner     <= 1'b0;
            sd_addr   <= '0;
            sd_data_o <= '0;
            rdata0    <= '0;
            rdata1    <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && grant) begin
                cur       <= win;
                owner     <= win;
                last      <= win;
                we_q      <= win ? we1 : we0;
                lock_q    <= win ? lock1 : lock0;
                sd_addr   <= win ? addr1 : addr0;
                sd_data_o <= win ? wdata1 : wdata0;
            end
            if (state == COMPLETE) begin
                locked <= lock_q;
                if (!we_q) begin
                    if (cur) rdata1 <= sd_data_i;
                    else     rdata0 <= sd_data_i;
                end
            end
            // Counts consecutive idle cycles the owner leaves unused.
            if (state != IDLE || !locked || own_req) begin
                tcnt <= '0;
            end else if (expire) begin
                tcnt   <= '0;
                locked <= 1'b0;
            end else begin
                tcnt <= tcnt + 1'b1;
            end
        end
    end

    assign sd_we = (state == ACCESS) & we_q & ~rst;
    assign ack0  = (state == COMPLETE) & ~cur & ~rst;
    assign ack1  = (state == COMPLETE) & cur & ~rst;
    assign busy  = (state != IDLE);

endmodule

// File: tb/tb_sd_reg_arbiter.sv
// Directed self-checking bench for sd_reg_arbiter.
// Inputs driven on negedge; outputs sampled on negedge.
module tb_sd_reg_arbiter;

    localparam int T = 256;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0, req1, we0, we1, lock0, lock1;
    logic [6:0] addr0, addr1;
    logic [7:0] wdata0, wdata1;
    logic       ack0, ack1;
    logic [7:0] rdata0, rdata1;
    logic [6:0] sd_addr;
    logic       sd_we;
    logic [7:0] sd_data_o;
    logic [7:0] sd_data_i;
    logic       owner, busy;

    int n_cmp = 0;
    int n_bad = 0;

    sd_reg_arbiter #(.LOCK_TIMEOUT(T)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1),
        .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1),
        .wdata0(wdata0), .wdata1(wdata1),
        .lock0(lock0), .lock1(lock1),
        .ack0(ack0), .ack1(ack1),
        .rdata0(rdata0), .rdata1(rdata1),
        .sd_addr(sd_addr), .sd_we(sd_we),
        .sd_data_o(sd_data_o), .sd_data_i(sd_data_i),
        .owner(owner), .busy(busy)
    );

    always #5 clk = ~clk;

    // Register file model: address 12 reads 3C, others addr ^ 55.
    always_comb begin
        sd_data_i = 8'({1'b0, sd_addr}) ^ 8'h55;
        if (sd_addr == 7'h12) sd_data_i = 8'h3C;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int aid[8];
        int act[8];
        int na;
        int both;
        int n0;
        int last0;
        int gap;
        logic seen;

        rst = 1'b1;
        {req0, req1, we0, we1, lock0, lock1} = '0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_owner", owner, 0);
        chk("rst_sd_we", sd_we, 0);
        chk("rst_sd_addr", sd_addr, 0);
        chk("rst_sd_data_o", sd_data_o, 0);
        chk("rst_acks", {ack0, ack1}, 0);
        chk("rst_rdata", {rdata0, rdata1}, 0);
        rst = 1'b0;

        // Write from requester 0
        req0 = 1; we0 = 1; addr0 = 7'h05; wdata0 = 8'hA5;
        @(negedge clk);
        req0 = 0; addr0 = 7'h7F; wdata0 = 8'h00;
        chk("wr_addr", sd_addr, 7'h05);
        chk("wr_data", sd_data_o, 8'hA5);
        chk("wr_we_k1", sd_we, 1);
        chk("wr_ack_k1", ack0, 0);
        chk("wr_busy", busy, 1);
        @(negedge clk);
        chk("wr_we_k2", sd_we, 0);
        chk("wr_ack_k2", {ack0, ack1}, 2'b10);
        chk("wr_addr_hold", sd_addr, 7'h05);
        @(negedge clk);
        chk("wr_ack_k3", ack0, 0);
        chk("wr_idle", busy, 0);

        // Read from requester 1
        req1 = 1; we1 = 0; addr1 = 7'h12;
        @(negedge clk);
        req1 = 0;
        chk("rd1_we", sd_we, 0);
        chk("rd1_owner", owner, 1);
        @(negedge clk);
        chk("rd1_ack", {ack0, ack1}, 2'b01);
        chk("rd1_we2", sd_we, 0);
        @(negedge clk);
        chk("rd1_rdata", rdata1, 8'h3C);
        chk("rd1_rdata0", rdata0, 8'h00);

        // Read from requester 0; rdata1 must hold
        req0 = 1; we0 = 0; addr0 = 7'h20;
        @(negedge clk);
        req0 = 0;
        @(negedge clk);
        chk("rd0_ack", ack0, 1);
        @(negedge clk);
        chk("rd0_rdata", rdata0, 8'h75);
        chk("rd0_rdata1", rdata1, 8'h3C);

        // Contention from reset
        do_reset();
        req0 = 1; req1 = 1; we0 = 0; we1 = 0;
        addr0 = 7'h01; addr1 = 7'h02;
        na = 0; both = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (ack0 && ack1) both++;
            if ((ack0 || ack1) && na < 8) begin
                aid[na] = ack1 ? 1 : 0;
                act[na] = c;
                na++;
            end
        end
        req0 = 0; req1 = 0;
        chk("rr_both", both, 0);
        chk("rr_count", (na >= 4), 1);
        if (na >= 4) begin
            chk("rr_g0", aid[0], 0);
            chk("rr_g1", aid[1], 1);
            chk("rr_g2", aid[2], 0);
            chk("rr_g3", aid[3], 1);
            chk("rr_gap1", act[1] - act[0], 3);
            chk("rr_gap3", act[3] - act[2], 3);
        end

        // Lock: lock0 on first two accesses, released on third
        do_reset();
        req0 = 1; req1 = 1; lock0 = 1; we0 = 0; we1 = 0;
        n0 = 0; last0 = 0; seen = 0; both = 0;
        for (int c = 0; c < 60 && !seen; c++) begin
            @(negedge clk);
            if (ack0 && ack1) both++;
            if (ack0) begin
                n0++;
                last0 = c;
                if (n0 == 2) lock0 = 0;
                if (n0 == 3) req0 = 0;
            end
            if (ack1) begin
                seen = 1;
                chk("lock_order", n0, 3);
                chk("lock_gap", c - last0, 3);
                req1 = 0;
            end
        end
        chk("lock_seen", seen, 1);
        chk("lock_both", both, 0);

        // Lock timeout
        do_reset();
        req0 = 1; lock0 = 1; we0 = 1; addr0 = 7'h10; wdata0 = 8'h11;
        seen = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (ack0) begin
                seen = 1;
                req0 = 0; lock0 = 0; req1 = 1; we1 = 0;
            end
        end
        chk("to_ack0", seen, 1);
        seen = 0; gap = 0;
        for (int c = 0; c < T + 40 && !seen; c++) begin
            @(negedge clk);
            gap++;
            if (ack1) seen = 1;
        end
        req1 = 0;
        chk("to_seen", seen, 1);
        chk("to_gap", gap, T + 3);

        // Reset during the access cycle of a write
        @(negedge clk);
        @(negedge clk);
        req0 = 1; we0 = 1; addr0 = 7'h33; wdata0 = 8'h77;
        @(posedge clk);
        #1 rst = 1;
        @(negedge clk);
        req0 = 0;
        chk("ra_busy", busy, 1);
        chk("ra_we", sd_we, 0);
        chk("ra_ack", {ack0, ack1}, 0);
        @(negedge clk);
        chk("ra_post_busy", busy, 0);
        chk("ra_post_addr", sd_addr, 0);
        chk("ra_post_data", sd_data_o, 0);
        chk("ra_post_owner", owner, 0);
        chk("ra_post_rdata", {rdata0, rdata1}, 0);
        rst = 0;
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (sd_we || ack0 || ack1) seen = 1;
        end
        chk("ra_quiet", seen, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
